// File: rtl/digital_lock_pkg.sv
// digital_lock_pkg: shared types and constants for the keypad digital lock.
//   - state_t       : lock controller states
//   - KEY_*         : one-hot key codes (key bit index + 1 is the numeral)
//   - SEG_*         : active-low 7-segment glyphs, bit order {dp,g,f,e,d,c,b,a}
//   - TIMEOUT_SECONDS, MAX_DIGITS
//   - is_onehot()   : legal-press test
//   - digit_seg()   : glyph for an entered digit (numeral or masked dash)
package digital_lock_pkg;

  typedef enum logic [2:0] {
    UNL_ENTRY1,
    UNL_ENTRY2,
    UNL_CHECK,
    LCK_ENTRY,
    LCK_CHECK
  } state_t;

  localparam int MAX_DIGITS      = 6;   // one digit per display
  localparam int TIMEOUT_SECONDS = 10;

  localparam logic [3:0] KEY_1 = 4'b0001;
  localparam logic [3:0] KEY_2 = 4'b0010;
  localparam logic [3:0] KEY_3 = 4'b0100;
  localparam logic [3:0] KEY_4 = 4'b1000;

  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // mask=1 hides the entered value behind a dash.
  function automatic logic [7:0] digit_seg(input logic [3:0] d, input logic mask);
    logic [7:0] seg;
    case (d)
      KEY_1:   seg = SEG_1;
      KEY_2:   seg = SEG_2;
      KEY_3:   seg = SEG_3;
      KEY_4:   seg = SEG_4;
      default: seg = SEG_BLANK;
    endcase
    if (mask && (seg != SEG_BLANK)) seg = SEG_DASH;
    return seg;
  endfunction

endpackage

// File: rtl/digital_lock_key_capture.sv
// digital_lock_key_capture: registers the raw key vector, detects rising
// edges of the registered vector and qualifies them as a legal press.
//   clock  : system clock
//   reset  : asynchronous, active-low
//   key    : raw key levels, one bit per key
//   press  : one-cycle strobe, a single key newly went high
//   digit  : the one-hot digit of that press (valid while press=1)
// A held key produces one press; simultaneous new keys are ignored.
module digital_lock_key_capture
  import digital_lock_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key,
  output logic       press,
  output logic [3:0] digit
);

  logic [3:0] key_q;
  logic [3:0] key_prev;
  logic [3:0] rise;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse key_prev into key_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_q    <= '0;
      key_prev <= '0;
    end else begin
      key_q    <= key;
      key_prev <= key_q;
    end
  end

  assign rise  = key_q & ~key_prev;
  assign press = is_onehot(rise);
  assign digit = rise;

endmodule

// File: rtl/digital_lock.sv
// digital_lock: keypad passcode lock controller.
//   clock    : system clock
//   reset    : asynchronous, active-low; clears everything incl. the passcode
//   key      : four active-high one-hot key pulses
//   locked   : 1 = locked
//   error    : 1 = last completed entry was rejected
//   displays : six active-low 7-seg codes {dp,g..a}, display 0 at [7:0]
// Parameters: CLOCK_FREQ (Hz, sets the 10 s idle timeout),
//             PASSCODE_LENGTH (digits per code, 1..6).
// Build option: define DIGITAL_LOCK_MASK_EN to show entered digits as '-'.
module digital_lock
  import digital_lock_pkg::*;
#(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int PASSCODE_LENGTH = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key,
  output logic        locked,
  output logic        error,
  output logic [47:0] displays
);

  localparam int     CODE_W         = 4 * PASSCODE_LENGTH;
  localparam int     CNT_W          = $clog2(PASSCODE_LENGTH + 1);
  localparam longint TIMEOUT_CYCLES = longint'(CLOCK_FREQ) * TIMEOUT_SECONDS;
  localparam int     TMR_W          = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_DIGIT   = CNT_W'(PASSCODE_LENGTH - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef DIGITAL_LOCK_MASK_EN
  localparam logic MASK_DIGITS = 1'b1;
`else
  localparam logic MASK_DIGITS = 1'b0;
`endif

  logic       press;
  logic [3:0] digit;

  digital_lock_key_capture u_key_capture (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .press (press),
    .digit (digit)
  );

  state_t             state_q,     state_d;
  logic [CODE_W-1:0]  buffer_q,    buffer_d;
  logic [CODE_W-1:0]  candidate_q, candidate_d;
  logic [CODE_W-1:0]  passcode_q,  passcode_d;
  logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
  logic [CNT_W-1:0]   shown_cnt_q, shown_cnt_d;  // digits currently on display
  logic [TMR_W-1:0]   timer_q,     timer_d;
  logic               locked_q,    locked_d;
  logic               error_q,     error_d;
  logic               show_err_q,  show_err_d;

  logic               entering;
  logic               accept;
  logic               timer_run;
  logic [CODE_W-1:0]  buf_ins;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    buffer_d    = buffer_q;
    candidate_d = candidate_q;
    passcode_d  = passcode_q;
    digit_cnt_d = digit_cnt_q;
    shown_cnt_d = shown_cnt_q;
    timer_d     = '0;
    locked_d    = locked_q;
    error_d     = error_q;
    show_err_d  = show_err_q;

    entering  = (state_q == UNL_ENTRY1) || (state_q == UNL_ENTRY2) ||
                (state_q == LCK_ENTRY);
    accept    = press && entering;
    timer_run = (digit_cnt_q != '0) || (state_q == UNL_ENTRY2);

    // Start a fresh buffer on the first digit, then drop the digit into its
    // nibble (first digit lands in the MSB nibble).
    buf_ins = (digit_cnt_q == '0) ? '0 : buffer_q;
    for (int i = 0; i < PASSCODE_LENGTH; i++) begin
      if (i == int'(digit_cnt_q)) buf_ins[4*(PASSCODE_LENGTH-1-i) +: 4] = digit;
    end

    if (accept) begin
      buffer_d    = buf_ins;
      shown_cnt_d = digit_cnt_q + CNT_W'(1);
      show_err_d  = 1'b0;
      if (digit_cnt_q == '0) error_d = 1'b0;
      if (digit_cnt_q == LAST_DIGIT) begin
        digit_cnt_d = '0;
        case (state_q)
          UNL_ENTRY1: begin
            candidate_d = buf_ins;
            state_d     = UNL_ENTRY2;
          end
          UNL_ENTRY2: state_d = UNL_CHECK;
          LCK_ENTRY:  state_d = LCK_CHECK;
          default:    state_d = state_q;
        endcase
      end else begin
        digit_cnt_d = digit_cnt_q + CNT_W'(1);
      end
    end else if (timer_run) begin
      if (timer_q == TIMEOUT_LAST) begin
        // Abandon the partial entry; lock status and error flag are kept.
        digit_cnt_d = '0;
        shown_cnt_d = '0;
        buffer_d    = '0;
        candidate_d = '0;
        state_d     = locked_q ? LCK_ENTRY : UNL_ENTRY1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    // The buffer still holds the just-completed entry during a CHECK cycle.
    case (state_q)
      UNL_CHECK: begin
        if (buffer_q == candidate_q) begin
          passcode_d = candidate_q;
          locked_d   = 1'b1;
          error_d    = 1'b0;
          state_d    = LCK_ENTRY;
        end else begin
          error_d    = 1'b1;
          show_err_d = 1'b1;
          state_d    = UNL_ENTRY1;
        end
      end
      LCK_CHECK: begin
        if (buffer_q == passcode_q) begin
          locked_d = 1'b0;
          error_d  = 1'b0;
          state_d  = UNL_ENTRY1;
        end else begin
          error_d    = 1'b1;
          show_err_d = 1'b1;
          state_d    = LCK_ENTRY;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the code registers are plain flops, not a RAM, so they are cleared
  // by reset like all other state; a reset deliberately forgets the passcode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= UNL_ENTRY1;
      buffer_q    <= '0;
      candidate_q <= '0;
      passcode_q  <= '0;
      digit_cnt_q <= '0;
      shown_cnt_q <= '0;
      timer_q     <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      show_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buffer_q    <= buffer_d;
      candidate_q <= candidate_d;
      passcode_q  <= passcode_d;
      digit_cnt_q <= digit_cnt_d;
      shown_cnt_q <= shown_cnt_d;
      timer_q     <= timer_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      show_err_q  <= show_err_d;
    end
  end

  // Left-align the buffer in a six-digit field so display k always reads
  // the k-th entered digit regardless of PASSCODE_LENGTH.
  logic [4*MAX_DIGITS-1:0] buf_wide;
  assign buf_wide = (4*MAX_DIGITS)'(buffer_q) << (4 * (MAX_DIGITS - PASSCODE_LENGTH));

  always_comb begin
    displays = {MAX_DIGITS{SEG_BLANK}};
    if (show_err_q) begin
      displays[23:0] = {SEG_E, SEG_R, SEG_R};
    end else begin
      for (int k = 0; k < MAX_DIGITS; k++) begin
        if (k < int'(shown_cnt_q))
          displays[8*k +: 8] = digit_seg(buf_wide[4*(MAX_DIGITS-1-k) +: 4], MASK_DIGITS);
      end
    end
  end

  assign locked = locked_q;
  assign error  = error_q;

endmodule

// File: tb/tb_digital_lock.sv
// tb_digital_lock: scoreboard bench for digital_lock (CLOCK_FREQ=50 so the
// idle timeout is 500 cycles). Stimulus pushes every expected change of
// {locked, error, displays}; the monitor pops one entry per observed change.
module tb_digital_lock;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key   = 4'b0000;
  logic        locked;
  logic        error;
  logic [47:0] displays;

  digital_lock #(.CLOCK_FREQ(50), .PASSCODE_LENGTH(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .key      (key),
    .locked   (locked),
    .error    (error),
    .displays (displays)
  );

  always #5 clock = ~clock;

  typedef logic [49:0] snap_t;  // {locked, error, displays}

  snap_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;
  snap_t last_exp;

  // Bench-side expectation state.
  logic [3:0] m_digits[6];
  int         m_shown;
  int         m_cnt;
  logic       m_locked;
  logic       m_error;
  logic       m_errdisp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] d);
`ifdef DIGITAL_LOCK_MASK_EN
    return 8'hBF;
`else
    case (d)
      4'b0001: return 8'hF9;  // '1'
      4'b0010: return 8'hA4;  // '2'
      4'b0100: return 8'hB0;  // '3'
      4'b1000: return 8'h99;  // '4'
      default: return 8'hFF;
    endcase
`endif
  endfunction

  function automatic snap_t expected_snap();
    logic [47:0] d;
    d = {6{8'hFF}};
    if (m_errdisp) begin
      d[23:0] = 24'h86AFAF;  // "Err"
    end else begin
      for (int k = 0; k < 6; k++)
        if (k < m_shown) d[8*k +: 8] = glyph(m_digits[k]);
    end
    return {m_locked, m_error, d};
  endfunction

  task automatic push_if_changed();
    snap_t s;
    s = expected_snap();
    if (s !== last_exp) begin
      sb.push_back(s);
      last_exp = s;
    end
  endtask

  task automatic model_reset();
    m_shown = 0; m_cnt = 0;
    m_locked = 1'b0; m_error = 1'b0; m_errdisp = 1'b0;
    for (int k = 0; k < 6; k++) m_digits[k] = 4'b0000;
  endtask

  // Drive one key press; when 'last', the check result must already be
  // visible three clock edges after the key goes high.
  task automatic drive(input logic [3:0] d, input int hold, input bit last);
    key = d;
    repeat (3) @(negedge clock);
    #1;
    if (last) check("latency", 64'(sb.size()), 64'd0);
    if (hold > 3) repeat (hold - 3) @(negedge clock);
    key = 4'b0000;
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d, input int hold, input bit last,
                             input logic exp_l, input logic exp_e);
    if (m_cnt == 0) begin
      m_shown = 0;
      m_error = 1'b0;
    end
    m_errdisp = 1'b0;
    m_digits[m_shown] = d;
    m_shown++;
    m_cnt++;
    push_if_changed();
    if (last) begin
      m_cnt     = 0;
      m_locked  = exp_l;
      m_error   = exp_e;
      m_errdisp = exp_e;
      push_if_changed();
    end
    drive(d, hold, last);
  endtask

  task automatic enter_code(input logic [23:0] code, input logic exp_l, input logic exp_e);
    for (int i = 0; i < 6; i++)
      press_digit(code[4*(5-i) +: 4], 3, (i == 5), exp_l, exp_e);
  endtask

  // Monitor: one scoreboard pop per observed output change.
  initial begin : monitor
    snap_t prev, cur;
    wait (mon_en);
    prev = {locked, error, displays};
    forever begin
      @(negedge clock);
      cur = {locked, error, displays};
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change: got %h expected no change from %h", cur, prev);
        end else begin
          check("scoreboard", 64'(cur), 64'(sb.pop_front()));
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    model_reset();
    last_exp = expected_snap();

    // Reset state.
    #3 reset = 1'b0;
    #1;
    check("reset_locked",   64'(locked),   64'd0);
    check("reset_error",    64'(error),    64'd0);
    check("reset_displays", 64'(displays), 64'hFFFF_FFFF_FFFF);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    mon_en = 1'b1;
    @(negedge clock);
    #1;

    // 1. Set and lock with 0x124812.
    enter_code(24'h124812, 1'b0, 1'b0);
    enter_code(24'h124812, 1'b1, 1'b0);

    // 3a. Unlock with the stored code.
    enter_code(24'h124812, 1'b0, 1'b0);

    // 2. Confirmation mismatch while unlocked -> error, "Err".
    enter_code(24'h124812, 1'b0, 1'b0);
    enter_code(24'h124811, 1'b0, 1'b1);

    // 4. First entry, idle past the timeout, then two more entries to lock.
    enter_code(24'h124812, 1'b0, 1'b0);  // first press also clears error
    m_shown = 0;
    m_cnt   = 0;
    push_if_changed();                   // timeout blanks the displays
    repeat (501) @(negedge clock);
    #1;
    check("timeout_fired", 64'(sb.size()), 64'd0);
    enter_code(24'h124812, 1'b0, 1'b0);  // discarded entry -> still unlocked
    enter_code(24'h124812, 1'b1, 1'b0);

    // 3b. Wrong code while locked.
    enter_code(24'h818181, 1'b1, 1'b1);

    // 5. Illegal two-key press ignored; held key counts once.
    drive(4'b0011, 3, 1'b0);
    press_digit(4'b0001, 20, 1'b0, m_locked, m_error);

    // 6. Two more digits, then reset mid-entry while locked.
    press_digit(4'b0010, 3, 1'b0, m_locked, m_error);
    press_digit(4'b0100, 3, 1'b0, m_locked, m_error);
    model_reset();
    push_if_changed();
    reset = 1'b0;
    #1;
    check("midreset_locked",   64'(locked),   64'd0);
    check("midreset_error",    64'(error),    64'd0);
    check("midreset_displays", 64'(displays), 64'hFFFF_FFFF_FFFF);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;

    // Passcode was lost: a fresh code must be set twice, then unlocks.
    enter_code(24'h421842, 1'b0, 1'b0);
    enter_code(24'h421842, 1'b1, 1'b0);
    enter_code(24'h421842, 1'b0, 1'b0);

    repeat (10) @(negedge clock);
    #1;
    check("queue_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
